// File: rtl/mlp_weight_sequencer.sv
// mlp_weight_sequencer: loads the activation LUT and the layer-1/layer-2
// weight RAMs from a valid/ready word stream, then runs inference on
// command by sweeping the RAM address space and flagging valid results.
// Optional feature macro: MLP_SEQ_CHECKSUM_EN (trailing checksum word).
module mlp_weight_sequencer #(
  parameter int N_L1      = 784,
  parameter int N_L2      = 10,
  parameter int DEPTH     = 64,
  parameter int LUT_DEPTH = 256,
  parameter int PIPE_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 run_start,
  input  logic                 s_valid,
  input  logic [15:0]          s_data,
  output logic                 s_ready,
  output logic [1:0]           en,
  output logic [N_L1+N_L2-1:0] we,
  output logic                 active_we,
  output logic [17:0]          addr,
  output logic [15:0]          wdata,
  output logic                 busy,
  output logic                 loaded,
  output logic                 result_valid,
  output logic                 chk_err
);

  localparam int NW = N_L1 + N_L2;
  localparam int BW = (N_L1 > 1) ? $clog2(N_L1) : 1;

`ifdef MLP_SEQ_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LD_LUT, LD_L1, LD_L2, LD_CHK, READY, RUN, DRAIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, LD_LUT, LD_L1, LD_L2, READY, RUN, DRAIN} state_t;
`endif

  state_t          state_q;
  logic [17:0]     cnt_q;     // word address during load, sweep/drain count during run
  logic [BW-1:0]   bank_q;
  logic [1:0]      en_q;
  logic [NW-1:0]   we_q;
  logic            active_we_q;
  logic [17:0]     addr_q;
  logic [15:0]     wdata_q;
  logic            loaded_q;
  logic            rv_q;
  logic            xfer;

  assign s_ready = (state_q == LD_LUT) || (state_q == LD_L1) || (state_q == LD_L2)
`ifdef MLP_SEQ_CHECKSUM_EN
                   || (state_q == LD_CHK)
`endif
                   ;
  assign busy = (state_q != IDLE) && (state_q != READY);
  assign xfer = s_valid && s_ready;

`ifdef MLP_SEQ_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        chk_err_q;
  assign chk_err = chk_err_q;

  // Running 16-bit sum of every data word; compared against the trailing word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (load_start && !busy) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (xfer && state_q != LD_CHK) begin
      sum_q <= sum_q + s_data;
    end else if (xfer && state_q == LD_CHK) begin
      chk_err_q <= (s_data != sum_q);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  // Main sequencer: state, counters and registered write/run outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= '0;
      en_q        <= '0;
      we_q        <= '0;
      active_we_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      loaded_q    <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      // strobes are single-cycle; en only persists through RUN/DRAIN
      we_q        <= '0;
      active_we_q <= 1'b0;
      en_q        <= '0;
      rv_q        <= 1'b0;
      case (state_q)
        IDLE, READY: begin
          if (load_start) begin
            state_q  <= LD_LUT;
            loaded_q <= 1'b0;
            cnt_q    <= '0;
            bank_q   <= '0;
          end else if (run_start && state_q == READY) begin
            state_q <= RUN;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 2'b11;
          end
        end
        LD_LUT: if (xfer) begin
          active_we_q <= 1'b1;
          addr_q      <= cnt_q;
          wdata_q     <= s_data;
          if (cnt_q == 18'(LUT_DEPTH-1)) begin
            cnt_q   <= '0;
            state_q <= LD_L1;
          end else cnt_q <= cnt_q + 18'd1;
        end
        LD_L1: if (xfer) begin
          we_q    <= NW'(1) << bank_q;
          en_q    <= 2'b01;
          addr_q  <= cnt_q;
          wdata_q <= s_data;
          if (cnt_q == 18'(DEPTH-1)) begin
            cnt_q <= '0;
            if (bank_q == BW'(N_L1-1)) begin
              bank_q  <= '0;
              state_q <= LD_L2;
            end else bank_q <= bank_q + BW'(1);
          end else cnt_q <= cnt_q + 18'd1;
        end
        LD_L2: if (xfer) begin
          we_q    <= NW'(1) << (N_L1 + int'(bank_q));
          en_q    <= 2'b10;
          addr_q  <= cnt_q;
          wdata_q <= s_data;
          if (cnt_q == 18'(DEPTH-1)) begin
            cnt_q <= '0;
            if (bank_q == BW'(N_L2-1)) begin
              bank_q <= '0;
`ifdef MLP_SEQ_CHECKSUM_EN
              state_q <= LD_CHK;
`else
              state_q  <= READY;
              loaded_q <= 1'b1;
`endif
            end else bank_q <= bank_q + BW'(1);
          end else cnt_q <= cnt_q + 18'd1;
        end
`ifdef MLP_SEQ_CHECKSUM_EN
        // checksum word produces no write; load counts as complete either way
        LD_CHK: if (xfer) begin
          state_q  <= READY;
          loaded_q <= 1'b1;
        end
`endif
        RUN: begin
          en_q <= 2'b11;
          if (cnt_q == 18'(DEPTH-1)) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
            rv_q    <= (PIPE_LAT == 1);
          end else begin
            cnt_q  <= cnt_q + 18'd1;
            addr_q <= cnt_q + 18'd1;
          end
        end
        DRAIN: begin
          if (cnt_q == 18'(PIPE_LAT-1)) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            en_q  <= 2'b11;
            cnt_q <= cnt_q + 18'd1;
            rv_q  <= (cnt_q + 18'd1 == 18'(PIPE_LAT-1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en           = en_q;
  assign we           = we_q;
  assign active_we    = active_we_q;
  assign addr         = addr_q;
  assign wdata        = wdata_q;
  assign loaded       = loaded_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_mlp_weight_sequencer.sv
// Directed bench for mlp_weight_sequencer in a small configuration
// (4 L1 banks, 2 L2 banks, depth 3, LUT depth 4, pipeline latency 2).
module tb_mlp_weight_sequencer;
  localparam int N_L1 = 4, N_L2 = 2, DEPTH = 3, LUT_DEPTH = 4, PIPE_LAT = 2;
  localparam int NWORDS = LUT_DEPTH + (N_L1 + N_L2) * DEPTH;  // 22

  logic        clk = 1'b0, reset = 1'b1;
  logic        load_start = 1'b0, run_start = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, active_we, busy, loaded, result_valid, chk_err;
  logic [1:0]  en;
  logic [5:0]  we;
  logic [17:0] addr;
  logic [15:0] wdata;

  int tests = 0, fails = 0;

  typedef struct {
    logic [5:0]  we;
    logic        aw;
    logic [17:0] a;
    logic [15:0] d;
    logic [1:0]  e;
  } wr_t;
  wr_t log_q[$];

  mlp_weight_sequencer #(.N_L1(N_L1), .N_L2(N_L2), .DEPTH(DEPTH),
                         .LUT_DEPTH(LUT_DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .run_start(run_start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .en(en), .we(we),
    .active_we(active_we), .addr(addr), .wdata(wdata), .busy(busy),
    .loaded(loaded), .result_valid(result_valid), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // record every write cycle seen on the RAM/LUT buses
  always @(negedge clk)
    if (!reset && (we != '0 || active_we)) log_q.push_back('{we, active_we, addr, wdata, en});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log();
    chk("nwr", 64'(log_q.size()), 64'(NWORDS));
    for (int i = 0; i < NWORDS && i < log_q.size(); i++) begin
      chk($sformatf("wd%0d", i), log_q[i].d, 16'h0100 + 16'(i));
      if (i < LUT_DEPTH) begin
        chk($sformatf("lut%0d", i), {log_q[i].aw, log_q[i].we, log_q[i].a}, {1'b1, 6'd0, 18'(i)});
      end else begin
        int j = i - LUT_DEPTH;
        chk($sformatf("w%0d", i), {log_q[i].aw, log_q[i].we, log_q[i].a},
            {1'b0, 6'd1 << (j / DEPTH), 18'(j % DEPTH)});
        chk($sformatf("en%0d", i), log_q[i].e, (j / DEPTH < N_L1) ? 2'b01 : 2'b10);
      end
    end
  endtask

  // full load; gaps inserts an idle cycle before every word, off skews the checksum
  task automatic do_load(input bit gaps, input int off);
    log_q.delete();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    chk("ld_ready", {s_ready, busy, loaded}, 3'b110);
    for (int i = 0; i < NWORDS; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        @(negedge clk);
        if (i > 0) chk("stall", {we, active_we}, 7'd0);
      end
      s_valid = 1'b1;
      s_data  = 16'h0100 + 16'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
`ifdef MLP_SEQ_CHECKSUM_EN
    chk("pre_chk", loaded, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'h16E7 + 16'(off);
    @(negedge clk) s_valid = 1'b0;
    chk("chk_err", chk_err, off != 0);
`else
    chk("chk_err", chk_err, 1'b0);
    if (off != 0) chk("off", 64'(off), 64'd0);
`endif
    chk("loaded", {loaded, busy, s_ready}, 3'b100);
    @(negedge clk);
    check_log();
  endtask

  // run; poke drives load_start mid-run, which must be ignored
  task automatic do_run(input bit poke);
    @(negedge clk) run_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      run_start  = 1'b0;
      load_start = poke && (k == 2);
      chk($sformatf("run%0d", k), {addr, en, result_valid, busy},
          {(k >= 3 ? 18'd2 : 18'(k - 1)), (k <= 5 ? 2'b11 : 2'b00), 1'(k == 5), 1'(k <= 5)});
    end
    load_start = 1'b0;
    chk("run_end", {loaded, s_ready}, 2'b10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst", {s_ready, en, we, active_we, addr, wdata, busy, loaded, result_valid, chk_err}, 64'd0);
    reset = 1'b0;

    // run_start before any load is ignored
    @(negedge clk) run_start = 1'b1;
    @(negedge clk) run_start = 1'b0;
    chk("run_idle", {busy, en, addr, s_ready}, 22'd0);
    @(negedge clk);
    chk("run_idle2", {busy, en, result_valid}, 4'd0);

    do_load(1'b0, 0);

    // no 23rd word: s_ready low in READY
    s_valid = 1'b1;
    s_data  = 16'h1234;
    chk("rdy_23", s_ready, 1'b0);
    @(negedge clk);
    @(negedge clk) s_valid = 1'b0;
    chk("no_23", {64'(log_q.size()), wdata}, {64'(NWORDS), 16'h0115});

    do_run(1'b0);
    do_run(1'b1);

    // reset in LD_L1 after 7 words
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0100 + 16'(i);
      @(negedge clk);
    end
    chk("mid_l1", {busy, en}, 3'b101);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    chk("rst_mid", {s_ready, en, we, active_we, addr, wdata, busy, loaded, result_valid, chk_err}, 64'd0);
    reset = 1'b0;

`ifdef MLP_SEQ_CHECKSUM_EN
    do_load(1'b1, 1);
`else
    do_load(1'b1, 0);
`endif
    do_run(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mlp_weight_sequencer.md
# mlp_weight_sequencer

Controller that sequences the two-layer MLP datapath. It streams the activation LUT and all layer-1/layer-2 weight RAM contents in from a valid/ready word stream, then runs inference on command. During a run it sweeps the ShiftRAM address space and signals when the results are valid. It sits between the host/loader interface and the top-level `en`/`we`/`active_we`/`addr`/`wdata` buses of the network.

## Interface
Parameters:
- `N_L1`, 784: layer-1 weight RAM count.
- `N_L2`, 10: layer-2 weight RAM count.
- `DEPTH`, 64: words per weight RAM (hidden neurons).
- `LUT_DEPTH`, 256: activation LUT words.
- `PIPE_LAT`, 4: datapath latency in cycles from the last run address to valid outputs.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_start`  in  1  pulse; begins a full load.
- `run_start`  in  1  pulse; begins an inference.
- `s_valid`  in  1  load word valid.
- `s_data`  in  16  load word.
- `s_ready`  out  1  sequencer accepts a word.
- `en`  out  2  `en[0]` drives the layer-1 RAM group, `en[1]` drives the layer-2 RAM group.
- `we`  out  N_L1+N_L2  one-hot RAM write strobe; bits `[N_L1-1:0]` are layer 1, the upper bits are layer 2.
- `active_we`  out  1  activation LUT write strobe.
- `addr`  out  18  RAM/LUT address.
- `wdata`  out  16  write data.
- `busy`  out  1  high in any state other than IDLE or READY.
- `loaded`  out  1  a complete load has finished since reset.
- `result_valid`  out  1  one-cycle pulse when outputs are valid.
- `chk_err`  out  1  checksum mismatch, sticky (see Configuration).

## Operation
- States: IDLE, LD_LUT, LD_L1, LD_L2, [LD_CHK], READY, RUN, DRAIN.
- IDLE or READY + `load_start` → LD_LUT. This clears `loaded`, clears the bank/address counters, and clears `chk_err`.
- `s_ready` = 1 only in the LD_* states. A transfer occurs when `s_valid` && `s_ready`. Stalls (`s_valid` = 0) hold all counters.
- LD_LUT: transfer k writes LUT address k (`active_we`=1). After word `LUT_DEPTH-1` → LD_L1.
- LD_L1: words are ordered bank-major: bank b = 0..N_L1-1, address a = 0..DEPTH-1. Each transfer pulses `we[b]` with `addr`=a and `en`=2'b01. After bank `N_L1-1`, address `DEPTH-1` → LD_L2.
- LD_L2: same ordering over banks 0..N_L2-1. Strobes `we[N_L1+b]` with `en`=2'b10. After the last word → LD_CHK if the checksum feature is compiled, else READY. `loaded` is set on entry to READY.
- Total load words = LUT_DEPTH + (N_L1+N_L2)·DEPTH, plus 1 with checksum.
- READY + `run_start` → RUN.
- RUN: `en`=2'b11 and `we`=0. `addr` steps 0..DEPTH-1, one per cycle. After `DEPTH-1` → DRAIN.
- DRAIN: `en`=2'b11, `addr` holds at `DEPTH-1`, for PIPE_LAT cycles. On the last DRAIN cycle `result_valid`=1; the next state is READY.
- Ignored commands:
  - `run_start` when not in READY (including IDLE with `loaded`=0).
  - `load_start` while `busy`.
  - If both pulses arrive in READY in the same cycle, `load_start` wins.
- Reset (at any time, including mid-load or mid-run): state → IDLE. All outputs are 0: `s_ready`, `en`, `we`, `active_we`, `addr`, `wdata`, `busy`, `loaded`, `result_valid`, `chk_err`.

## Timing
- Write outputs are registered. A transfer accepted in cycle t produces `we`/`active_we`/`addr`/`wdata` in cycle t+1, lasting exactly 1 cycle. Outside a write cycle, `we` and `active_we` are 0 and `wdata` holds its last value.
- A command in cycle t → new state in t+1. In LD_LUT, `s_ready` is high from t+1.
- The last load transfer in cycle t → its write in t+1, READY in t+1, `loaded`=1 in t+1.
- `run_start` in cycle t → RUN with `addr`=0 in t+1. `result_valid` is high in cycle t+DEPTH+PIPE_LAT. READY follows in the next cycle.
- Back-to-back transfers sustain 1 word/cycle.
- Counter widths: bank counter ⌈log2(N_L1)⌉ bits; address counter 18 bits. `addr` is zero-extended.

## Configuration
- `MLP_SEQ_CHECKSUM_EN` defined:
  - A 16-bit wrap-around sum of all load words except the last is accumulated.
  - LD_CHK accepts one extra word, compares it to the sum, and sets `chk_err`=1 on mismatch. `loaded` is still set in either case.
  - LD_CHK generates no write.
- Not defined: LD_CHK, the accumulator and the extra word do not exist, and `chk_err` is tied to 0.

## Test plan
Test configuration: N_L1=4, N_L2=2, DEPTH=3, LUT_DEPTH=4, PIPE_LAT=2.
- Reset, then `load_start`, then 22 words 0x0100+i streamed with no gaps:
  - words 0–3 → `active_we`, `addr` 0–3.
  - word 4 → `we`=6'b000001, `addr`=0, `wdata`=0x0104.
  - word 16 → `we`=6'b010000, `en`=2'b10.
  - `loaded`=1 the cycle after word 21.
- Same stream with `s_valid` toggling every other cycle → identical write sequence, one write per accepted word, no duplicates.
- After the load, `run_start` at cycle t → `addr` 0,1,2 at t+1..t+3; `result_valid` at t+5 only; READY at t+6.
- `run_start` issued before any load, and `load_start` issued during RUN → both ignored, state unchanged.
- `reset` asserted in LD_L1 after 7 words → all outputs 0 next cycle and `loaded`=0. A fresh full load then succeeds.
- With `MLP_SEQ_CHECKSUM_EN`: correct checksum word → `chk_err`=0. Checksum word off by 1 → `chk_err`=1 with `loaded`=1. Without the macro, a 23rd word is not accepted because `s_ready`=0 in READY.
